pc_sequencer: RTL and testbench

Next-PC controller for the MIPS pipeline front end. Each cycle it selects the value loaded into the `PC` register and drives its `PCWrite` enable, arbitrating between four sources: sequential fetch, branch/jump redirect, load-use stall and exception vectoring. It also sequences the wrong-path flush cycles after each redirect and holds the exception return address (EPC).

---
 rtl/pc_seq_pkg.sv | 23 ++
 rtl/pc_seq_stall_cnt.sv | 45 ++++
 rtl/pc_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
// Shared types and constants for the next-PC sequencer:
//   state_e            - sequencer FSM states
//   DEFAULT_EXC_VECTOR - reset default for the exception handler address
//   cnt_width()        - stall counter width for a given STALL_CYCLES
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_EXC   = 2'd3
    } state_e;

    localparam int DEFAULT_EXC_VECTOR = 60;

    // $clog2(N) bits always hold N-1, the largest value ever loaded.
    // Clamped to 1 so a single-cycle stall still yields a legal vector.
    function automatic int cnt_width(input int stall_cycles);
        return (stall_cycles > 1) ? $clog2(stall_cycles) : 1;
    endfunction

endpackage

// File: rtl/pc_seq_stall_cnt.sv
// pc_seq_stall_cnt
// Loadable down-counter that times the remaining frozen cycles of a stall.
// Ports:
//   clk_i      - clock, rising edge
//   rst_i      - synchronous active-high reset (count -> 0)
//   load_i     - load load_val_i (takes precedence over dec_i)
//   load_val_i - value to load
//   dec_i      - decrement by one (saturates at 0)
//   last_o     - count == 1, i.e. this is the final frozen cycle
module pc_seq_stall_cnt
    import pc_seq_pkg::*;
#(
    parameter int CNT_W = cnt_width(2)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Next-PC controller for the pipeline front end. Chooses the value loaded
// into the PC register each cycle (sequential, branch/jump redirect,
// load-use stall, exception vector / return), sequences the wrong-path
// flush cycle after each redirect and holds the exception return PC.
//
// Optional feature macro: PC_SEQ_EXC_EN
//   defined   - exception entry/return, epc and exc_active are built.
//   undefined - exc_req/eret ignored, epc and exc_active tied to 0.
//
// Ports:
//   clk, rst       - clock (rising edge), synchronous active-high reset
//   pc_cur         - current PC register value
//   stall_req      - load-use hazard pulse
//   branch_taken / branch_target - EX-stage taken branch and its target
//   jump / jump_target           - ID-stage jump and its target
//   exc_req, eret  - exception request, return from exception
//   pc_next        - value for PCin
//   pc_write       - PCWrite enable
//   flush_if       - kill the instruction in IF/ID
//   epc            - saved exception PC
//   exc_active     - inside the exception handler
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | normal fetch; all requests arbitrated
// STALL | PC frozen for the remainder of a load-use stall
// FLUSH | first sequential cycle after a redirect; wrong-path fetch killed
// EXC   | first cycle inside the handler; all requests ignored
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                  PC_WIDTH     = 6,
    parameter int                  STALL_CYCLES = 2,
    parameter logic [PC_WIDTH-1:0] EXC_VECTOR   = PC_WIDTH'(DEFAULT_EXC_VECTOR)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] pc_cur,
    input  logic                stall_req,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                exc_req,
    input  logic                eret,
    output logic [PC_WIDTH-1:0] pc_next,
    output logic                pc_write,
    output logic                flush_if,
    output logic [PC_WIDTH-1:0] epc,
    output logic                exc_active
);

    localparam int CNT_W = cnt_width(STALL_CYCLES);

    state_e state_q;
    state_e state_d;

    logic [PC_WIDTH-1:0] pc_seq;
    logic [PC_WIDTH-1:0] epc_ret;
    logic                exc_ok;
    logic                eret_ok;
    logic                in_run;
    logic                in_stall;
    logic                redir_ok;
    logic                take_exc;
    logic                take_eret;
    logic                take_br;
    logic                take_jmp;
    logic                stall_last;
    logic                cnt_load;
    logic                cnt_dec;

    assign pc_seq = pc_cur + PC_WIDTH'(1);

`ifdef PC_SEQ_EXC_EN
    logic [PC_WIDTH-1:0] epc_q;
    logic                exc_active_q;

    // No nesting: a new exception is dropped while inside the handler.
    assign exc_ok  = exc_req && !exc_active_q;
    assign eret_ok = eret && exc_active_q;
    assign epc_ret = epc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            epc_q        <= '0;
            exc_active_q <= 1'b0;
        end else if (take_exc) begin
            epc_q        <= pc_cur;
            exc_active_q <= 1'b1;
        end else if (take_eret) begin
            exc_active_q <= 1'b0;
        end
    end

    assign epc        = epc_q;
    assign exc_active = exc_active_q;
`else
    logic unused_exc;

    assign unused_exc = exc_req ^ eret;
    assign exc_ok     = 1'b0;
    assign eret_ok    = 1'b0;
    assign epc_ret    = '0;
    assign epc        = '0;
    assign exc_active = 1'b0;
`endif

    assign in_run    = (state_q == ST_RUN);
    assign in_stall  = (state_q == ST_STALL);
    // A stall is abandoned by any redirect, so STALL arbitrates like RUN.
    assign redir_ok  = in_run || in_stall;
    assign take_exc  = exc_ok && (redir_ok || (state_q == ST_FLUSH));
    assign take_eret = eret_ok && redir_ok;
    assign take_br   = branch_taken && redir_ok;
    assign take_jmp  = jump && redir_ok;

    // The request cycle counts as the first frozen cycle, so the counter
    // only covers the remaining STALL_CYCLES-1.
    assign cnt_load = in_run && (state_d == ST_STALL);
    assign cnt_dec  = in_stall;

    generate
        if (STALL_CYCLES > 1) begin : g_stall_cnt
            pc_seq_stall_cnt #(
                .CNT_W (CNT_W)
            ) u_stall_cnt (
                .clk_i      (clk),
                .rst_i      (rst),
                .load_i     (cnt_load),
                .load_val_i (CNT_W'(STALL_CYCLES - 1)),
                .dec_i      (cnt_dec),
                .last_o     (stall_last)
            );
        end else begin : g_no_stall_cnt
            logic unused_cnt;
            assign unused_cnt = cnt_load ^ cnt_dec;
            assign stall_last = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN, ST_STALL: begin
                if (take_exc) begin
                    state_d = ST_EXC;
                end else if (take_eret || take_br || take_jmp) begin
                    state_d = ST_FLUSH;
                end else if (in_run) begin
                    state_d = (stall_req && (STALL_CYCLES > 1)) ? ST_STALL : ST_RUN;
                end else begin
                    state_d = stall_last ? ST_RUN : ST_STALL;
                end
            end
            ST_FLUSH: state_d = take_exc ? ST_EXC : ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pc_next  = pc_seq;
        pc_write = 1'b1;
        flush_if = 1'b0;
        case (state_q)
            ST_RUN, ST_STALL: begin
                if (take_exc) begin
                    pc_next  = EXC_VECTOR;
                    flush_if = 1'b1;
                end else if (take_eret) begin
                    pc_next  = epc_ret;
                    flush_if = 1'b1;
                end else if (take_br) begin
                    pc_next  = branch_target;
                    flush_if = 1'b1;
                end else if (take_jmp) begin
                    pc_next  = jump_target;
                    flush_if = 1'b1;
                end else if (in_stall || stall_req) begin
                    pc_write = 1'b0;
                end
            end
            ST_FLUSH: begin
                flush_if = 1'b1;
                if (take_exc) begin
                    pc_next = EXC_VECTOR;
                end
            end
            default: begin
                flush_if = 1'b1;
            end
        endcase
        if (rst) begin
            pc_next  = '0;
            pc_write = 1'b0;
            flush_if = 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] pc_cur = '0;
    logic       stall_req = 1'b0;
    logic       branch_taken = 1'b0;
    logic [5:0] branch_target = '0;
    logic       jump = 1'b0;
    logic [5:0] jump_target = '0;
    logic       exc_req = 1'b0;
    logic       eret = 1'b0;
    logic [5:0] pc_next;
    logic       pc_write;
    logic       flush_if;
    logic [5:0] epc;
    logic       exc_active;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      nm;
        bit         chk_pn;
        logic [5:0] pn;
        logic       pw;
        logic       fl;
        logic [5:0] epc;
        logic       xa;
    } exp_t;

    exp_t sb[$];

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .pc_cur        (pc_cur),
        .stall_req     (stall_req),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .exc_req       (exc_req),
        .eret          (eret),
        .pc_next       (pc_next),
        .pc_write      (pc_write),
        .flush_if      (flush_if),
        .epc           (epc),
        .exc_active    (exc_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input string fld, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle; sampled mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.chk_pn) check(e.nm, "pc_next", int'(pc_next), int'(e.pn));
            check(e.nm, "pc_write",   int'(pc_write),   int'(e.pw));
            check(e.nm, "flush_if",   int'(flush_if),   int'(e.fl));
            check(e.nm, "epc",        int'(epc),        int'(e.epc));
            check(e.nm, "exc_active", int'(exc_active), int'(e.xa));
        end
    end

    // One cycle of stimulus plus its hand-computed response.
    // pn < 0 means pc_next is don't-care (PC not written).
    task automatic step(input string nm, input bit r, input int pc,
                        input bit st, input bit br, input int bt,
                        input bit j, input int jt, input bit ex, input bit er,
                        input int pn, input bit pw, input bit fl,
                        input int ep, input bit xa);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        pc_cur        = 6'(pc);
        stall_req     = st;
        branch_taken  = br;
        branch_target = 6'(bt);
        jump          = j;
        jump_target   = 6'(jt);
        exc_req       = ex;
        eret          = er;
        e.nm     = nm;
        e.chk_pn = (pn >= 0);
        e.pn     = 6'(pn);
        e.pw     = pw;
        e.fl     = fl;
        e.epc    = 6'(ep);
        e.xa     = xa;
        sb.push_back(e);
    endtask

    initial begin
        //     name        rst pc  st br bt j  jt ex er  pn pw fl epc xa
        step("rst0",       1, 0,  0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        step("rst_gate",   1, 7,  1, 1, 9, 1, 3, 1, 1,   0, 0, 0, 0, 0);
        step("run0",       0, 0,  0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
        step("run1",       0, 1,  0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0);
        step("run62",      0, 62, 0, 0, 0, 0, 0, 0, 0,  63, 1, 0, 0, 0);
        step("wrap63",     0, 63, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
        step("stall_req",  0, 5,  1, 0, 0, 0, 0, 0, 0,  -1, 0, 0, 0, 0);
        step("stall_2nd",  0, 5,  0, 0, 0, 0, 0, 0, 0,  -1, 0, 0, 0, 0);
        step("stall_done", 0, 5,  0, 0, 0, 0, 0, 0, 0,   6, 1, 0, 0, 0);
        step("st_norearm", 0, 6,  1, 0, 0, 0, 0, 0, 0,  -1, 0, 0, 0, 0);
        step("st_ignore",  0, 6,  1, 0, 0, 0, 0, 0, 0,  -1, 0, 0, 0, 0);
        step("st_exit",    0, 6,  0, 0, 0, 0, 0, 0, 0,   7, 1, 0, 0, 0);
        step("br_jmp",     0, 7,  0, 1, 20, 1, 40, 0, 0, 20, 1, 1, 0, 0);
        step("flush_ign",  0, 20, 0, 1, 50, 1, 40, 0, 0, 21, 1, 1, 0, 0);
        step("after_br",   0, 21, 0, 0, 0, 0, 0, 0, 0,  22, 1, 0, 0, 0);
        step("jmp",        0, 22, 0, 0, 0, 1, 40, 0, 0, 40, 1, 1, 0, 0);
        step("flush_st",   0, 40, 1, 0, 0, 0, 0, 0, 0,  41, 1, 1, 0, 0);
        step("after_jmp",  0, 41, 0, 0, 0, 0, 0, 0, 0,  42, 1, 0, 0, 0);
        step("st_for_br",  0, 42, 1, 0, 0, 0, 0, 0, 0,  -1, 0, 0, 0, 0);
        step("br_abort",   0, 42, 0, 1, 3, 0, 0, 0, 0,   3, 1, 1, 0, 0);
        step("br_flush",   0, 3,  0, 0, 0, 0, 0, 0, 0,   4, 1, 1, 0, 0);
        step("br_resume",  0, 4,  0, 0, 0, 0, 0, 0, 0,   5, 1, 0, 0, 0);
`ifdef PC_SEQ_EXC_EN
        step("exc",        0, 9,  0, 0, 0, 0, 0, 1, 0,  60, 1, 1, 0, 0);
        step("exc_state",  0, 60, 0, 0, 0, 0, 0, 1, 0,  61, 1, 1, 9, 1);
        step("exc_nonest", 0, 61, 0, 0, 0, 0, 0, 1, 0,  62, 1, 0, 9, 1);
        step("eret",       0, 62, 0, 1, 5, 0, 0, 0, 1,   9, 1, 1, 9, 1);
        step("eret_flush", 0, 9,  0, 0, 0, 0, 0, 0, 0,  10, 1, 1, 9, 0);
        step("eret_ign",   0, 10, 0, 0, 0, 0, 0, 0, 1,  11, 1, 0, 9, 0);
        step("st_for_exc", 0, 11, 1, 0, 0, 0, 0, 0, 0,  -1, 0, 0, 9, 0);
        step("exc_abort",  0, 11, 0, 0, 0, 0, 0, 1, 0,  60, 1, 1, 9, 0);
        step("exc2_state", 0, 60, 0, 0, 0, 0, 0, 0, 0,  61, 1, 1, 11, 1);
        step("exc2_run",   0, 61, 0, 0, 0, 0, 0, 0, 0,  62, 1, 0, 11, 1);
        step("st_mid_rst", 0, 62, 1, 0, 0, 0, 0, 0, 0,  -1, 0, 0, 11, 1);
        step("rst_mid",    1, 62, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 11, 1);
        step("post_rst",   0, 0,  0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
        step("br_pre_exc", 0, 1,  0, 1, 30, 0, 0, 0, 0, 30, 1, 1, 0, 0);
        step("exc_flush",  0, 30, 0, 0, 0, 0, 0, 1, 0,  60, 1, 1, 0, 0);
        step("exc3_state", 0, 60, 0, 0, 0, 0, 0, 0, 0,  61, 1, 1, 30, 1);
        step("exc3_run",   0, 61, 0, 0, 0, 0, 0, 0, 0,  62, 1, 0, 30, 1);
`else
        step("exc_off",    0, 9,  0, 0, 0, 0, 0, 1, 0,  10, 1, 0, 0, 0);
        step("eret_off",   0, 10, 0, 0, 0, 0, 0, 0, 1,  11, 1, 0, 0, 0);
        step("st_for_exc", 0, 11, 1, 0, 0, 0, 0, 0, 0,  -1, 0, 0, 0, 0);
        step("exc_noabrt", 0, 11, 0, 0, 0, 0, 0, 1, 0,  -1, 0, 0, 0, 0);
        step("st_exit2",   0, 11, 0, 0, 0, 0, 0, 0, 0,  12, 1, 0, 0, 0);
        step("st_mid_rst", 0, 12, 1, 0, 0, 0, 0, 0, 0,  -1, 0, 0, 0, 0);
        step("rst_mid",    1, 12, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        step("post_rst",   0, 0,  0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
`endif
        step("final_run",  0, 62, 0, 0, 0, 0, 0, 0, 0,  63, 1, 0, 0, 0);

        begin
            int guard;
            guard = 0;
            while (sb.size() > 0 && guard < 20) begin
                @(posedge clk);
                guard++;
            end
            n_tests++;
            if (sb.size() > 0) begin
                n_fail++;
                $display("FAIL drain: %0d entries left, expected 0", sb.size());
            end
        end
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
